// File: rtl/apb_master.sv
// apb_master
//   Bridges the CPU data port onto the peripheral APB bus. One request at a
//   time is latched in IDLE, then driven through SETUP and ACCESS. The CPU
//   is stalled until the selected slave raises its PREADY.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   transfer/write/addr/wdata   CPU request (sampled in IDLE only)
//   ready, rdata          CPU completion pulse and load data (combinational)
//   PADDR/PWDATA/PWRITE   latched request onto APB
//   PENABLE, PSEL0..4     APB phase and slave selects (RAM,GPO,GPI,GPIO,UART)
//   PRDATA0..4, PREADY0..4  per-slave read data and ready
//
// state  | meaning
// IDLE   | waiting for transfer; all selects low
// SETUP  | PSELx high, PENABLE low, one cycle
// ACCESS | PSELx and PENABLE high until selected PREADY (or unmapped)
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              transfer,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PENABLE,
  output logic              PSEL0,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PSEL3,
  output logic              PSEL4,
  input  logic [DATA_W-1:0] PRDATA0,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic [DATA_W-1:0] PRDATA3,
  input  logic [DATA_W-1:0] PRDATA4,
  input  logic              PREADY0,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic              PREADY3,
  input  logic              PREADY4
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state;
  logic [4:0]  pSel;
  logic [4:0]  pReadyVec;
  logic [19:0] addrPage;
  logic        accessDone;

  function automatic logic [4:0] decodePage(input logic [19:0] page);
    case (page)
      20'h10000: decodePage = 5'b00001;
      20'h10001: decodePage = 5'b00010;
      20'h10002: decodePage = 5'b00100;
      20'h10003: decodePage = 5'b01000;
      20'h10004: decodePage = 5'b10000;
      default:   decodePage = 5'b00000;
    endcase
  endfunction

  assign addrPage  = addr[31:12];
  assign pReadyVec = {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0};

  // An unmapped address has no select, so ACCESS completes at once rather
  // than waiting on a PREADY nobody will drive.
  assign accessDone = (state == ACCESS) && ((pSel == 5'b0) || ((pSel & pReadyVec) != 5'b0));
  assign ready      = accessDone;

  assign {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0} = pSel;

  always_comb begin
    rdata = '0;
    if (accessDone) begin
      if (pSel[0])      rdata = PRDATA0;
      else if (pSel[1]) rdata = PRDATA1;
      else if (pSel[2]) rdata = PRDATA2;
      else if (pSel[3]) rdata = PRDATA3;
      else if (pSel[4]) rdata = PRDATA4;
    end
  end

  // Selects are decoded from the incoming address when the request is
  // latched, so they come out of a flop together with PADDR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pSel    <= '0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            pSel   <= decodePage(addrPage);
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (accessDone) begin
            pSel    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          pSel    <= '0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
  logic [31:0] prd [0:4];
  logic [4:0]  pready;

  logic [31:0] slaveMem [0:255];
  logic [31:0] refMem   [0:255];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .PADDR(PADDR),
    .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
    .PRDATA0(prd[0]), .PRDATA1(prd[1]), .PRDATA2(prd[2]), .PRDATA3(prd[3]),
    .PRDATA4(prd[4]),
    .PREADY0(pready[0]), .PREADY1(pready[1]), .PREADY2(pready[2]),
    .PREADY3(pready[3]), .PREADY4(pready[4])
  );

  function automatic logic [4:0] pselVec();
    return {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: slave index is the 4 KB page offset from 0x1000_0000, valid 0..4.
  function automatic int slaveOf(input logic [31:0] a);
    longint page;
    page = longint'(a >> 12) - 64'h10000;
    if (page >= 0 && page <= 4) return int'(page);
    return -1;
  endfunction

  task automatic doXfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input bit midPulse, input logic [31:0] slvRd);
    int          sel;
    int          effWaits;
    logic [4:0]  expSel;
    logic [31:0] expRd;
    sel      = slaveOf(a);
    expSel   = (sel >= 0) ? 5'(1 << sel) : 5'b0;
    effWaits = (sel >= 0) ? waits : 0;
    for (int k = 1; k <= 4; k++) prd[k] = $urandom;
    if (sel >= 1) prd[sel] = slvRd;
    if (sel == 0)      expRd = refMem[a[9:2]];
    else if (sel > 0)  expRd = prd[sel];
    else               expRd = 32'h0;

    @(negedge clk);
    transfer = 1'b1; write = wr; addr = a; wdata = wd; pready = 5'b0;
    @(negedge clk);
    transfer = midPulse;
    if (midPulse) begin addr = $urandom; write = ~wr; wdata = $urandom; end
    pready = 5'($urandom);
    prd[0] = slaveMem[PADDR[9:2]];
    #1;
    check("setup_psel", pselVec(), expSel);
    check("setup_penable", PENABLE, 1'b0);
    check("setup_pwrite", PWRITE, wr);
    check("setup_paddr", PADDR, a);
    check("setup_pwdata", PWDATA, wd);
    check("setup_ready", ready, 1'b0);
    for (int k = 0; k <= effWaits; k++) begin
      @(negedge clk);
      transfer = midPulse;
      pready = 5'($urandom);
      if (sel >= 0) pready[sel] = (k == effWaits);
      prd[0] = slaveMem[PADDR[9:2]];
      #1;
      check("access_psel", pselVec(), expSel);
      check("access_penable", PENABLE, 1'b1);
      check("access_paddr", PADDR, a);
      check("access_ready", ready, (k == effWaits));
      check("access_rdata", rdata, (k == effWaits) ? expRd : 32'h0);
    end
    if (sel == 0 && wr) slaveMem[PADDR[9:2]] = PWDATA;
    @(negedge clk);
    transfer = 1'b0; pready = 5'b0;
    #1;
    check("idle_psel", pselVec(), 5'b0);
    check("idle_penable", PENABLE, 1'b0);
    check("idle_ready", ready, 1'b0);
    check("idle_rdata", rdata, 32'h0);
    check("idle_paddr_hold", PADDR, a);
    if (sel == 0 && wr) refMem[a[9:2]] = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin slaveMem[i] = 32'h0; refMem[i] = 32'h0; end
    for (int k = 0; k < 5; k++) prd[k] = 32'h0;
    rst = 1'b1; transfer = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0; pready = 5'b0;

    // Reset sweep
    @(negedge clk); @(negedge clk);
    check("rst_psel", pselVec(), 5'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", PWRITE, 1'b0);
    rst = 1'b0;
    pready = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("quiet_psel", pselVec(), 5'b0);
      check("quiet_ready", ready, 1'b0);
    end
    pready = 5'b0;

    // Store to RAM, zero wait; then read it back
    doXfer(1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    check("ram_holds", slaveMem[2], 32'hDEAD_BEEF);
    doXfer(1'b0, 32'h1000_0008, 32'h0, 1, 1'b0, 32'h0);

    // UART load, 3 wait cycles
    doXfer(1'b0, 32'h1000_4000, 32'h0, 3, 1'b0, 32'h0000_0041);

    // Unmapped load
    doXfer(1'b0, 32'h2000_0000, 32'h0, 2, 1'b0, 32'h0);

    // Reset during ACCESS to GPIO
    @(negedge clk);
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010;
    @(negedge clk);
    transfer = 1'b0;
    @(negedge clk);
    pready = 5'b0;
    #1;
    check("pre_rst_penable", PENABLE, 1'b1);
    check("pre_rst_psel3", PSEL3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pready = 5'b11111;
    #1;
    check("post_rst_psel", pselVec(), 5'b0);
    check("post_rst_penable", PENABLE, 1'b0);
    check("post_rst_ready", ready, 1'b0);
    @(negedge clk);
    check("post_rst_ready2", ready, 1'b0);
    pready = 5'b0;
    doXfer(1'b1, 32'h1000_3010, 32'h1234_5678, 1, 1'b0, 32'hA5A5_0001);

    // Back-to-back GPO then GPI with mid-transaction pulses
    doXfer(1'b1, 32'h1000_1004, 32'h0000_00FF, 2, 1'b1, 32'h0);
    doXfer(1'b0, 32'h1000_2000, 32'h0, 1, 1'b1, 32'hCAFE_0002);

    // Randomized mix
    for (int t = 0; t < 30; t++) begin
      int          s;
      logic [31:0] a;
      s = $urandom_range(0, 5);
      if (s == 5) a = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC);
      else        a = 32'h1000_0000 | (s << 12) | ($urandom_range(0, 15) << 2);
      doXfer(1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom), $urandom);
    end

    // Confirm RAM contents via loads
    for (int i = 0; i < 16; i++)
      doXfer(1'b0, 32'h1000_0000 | (i << 2), 32'h0, 0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Bus controller between the RV32I core's data port and the peripheral APB bus. It accepts one CPU load/store request at a time and sequences it through the APB SETUP and ACCESS phases. It decodes the address into one of five slave selects and stalls the CPU until the selected slave signals PREADY. It replaces the direct CPU-to-RAM data connection so that RAM and memory-mapped peripherals share one bus.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- transfer  in  1  CPU request strobe; single-cycle pulse, sampled in IDLE only
- write  in  1  1 = store, 0 = load; sampled with transfer
- addr  in  ADDR_W  byte address; sampled with transfer
- wdata  in  DATA_W  store data; sampled with transfer
- ready  out  1  transfer complete; one-cycle pulse
- rdata  out  DATA_W  load data; valid only while ready=1
- PADDR  out  ADDR_W  latched address
- PWDATA  out  DATA_W  latched write data
- PWRITE  out  1  latched direction
- PENABLE  out  1  ACCESS phase indicator
- PSEL0..PSEL4  out  1 each  slave selects: RAM, GPO, GPI, GPIO, UART
- PRDATA0..PRDATA4  in  DATA_W each  slave read data
- PREADY0..PREADY4  in  1 each  slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: when transfer=1, latch addr, wdata and write into PADDR, PWDATA and PWRITE, then go to SETUP. When transfer=0, stay in IDLE.
- SETUP: the decoded PSELx=1 and PENABLE=0. Go to ACCESS unconditionally.
- ACCESS: the decoded PSELx=1 and PENABLE=1.
  - When the selected PREADYx=1: ready=1, rdata=PRDATAx, next state IDLE.
  - Otherwise: stay in ACCESS with all APB outputs held stable.
- Address decode uses PADDR[31:12]:
  - 0x10000 → RAM (PSEL0)
  - 0x10001 → GPO (PSEL1)
  - 0x10002 → GPI (PSEL2)
  - 0x10003 → GPIO (PSEL3)
  - 0x10004 → UART (PSEL4)
- Unmapped address: no PSEL is asserted. The ACCESS phase completes immediately with ready=1 and rdata=0, so the CPU never hangs.
- At most one PSEL is high in any cycle. All PSEL signals are 0 in IDLE.
- transfer asserted outside IDLE is ignored; the CPU is stalled and must not issue requests then.
- PADDR, PWDATA and PWRITE hold their last latched values in IDLE and are not cleared.
- rdata is 0 whenever ready=0.

## Timing
- Reset, synchronous: the state is IDLE on the first edge with rst=1. At that point:
  - PSEL0..4=0, PENABLE=0, ready=0, rdata=0.
  - PADDR=0, PWDATA=0, PWRITE=0.
- rst asserted during SETUP or ACCESS: after that edge the state is IDLE and PSEL/PENABLE are low. The in-flight transfer is dropped and no ready is produced.
- Zero-wait transfer:
  - transfer sampled at edge N.
  - SETUP occupies cycle N..N+1.
  - ACCESS occupies cycle N+1..N+2, with ready high combinationally in that cycle.
  - Back in IDLE after edge N+2.
  - Minimum request-to-request spacing is 3 cycles.
- Each cycle of PREADYx=0 in ACCESS adds one cycle.
- ready and rdata are combinational from PREADYx/PRDATAx during ACCESS. There is no registered output stage.
- PREADYx is ignored in IDLE and SETUP.
- PREADY from a non-selected slave has no effect.

## Test plan
- Reset, then sweep all outputs: PSEL0..4=0, PENABLE=0, ready=0, rdata=0, PADDR=0. After rst is released, no activity occurs until transfer.
- Store, addr=0x1000_0008, wdata=0xDEAD_BEEF, PREADY0 tied 1:
  - SETUP: PSEL0=1, PENABLE=0, PWRITE=1.
  - ACCESS: PENABLE=1.
  - ready=1 exactly 2 cycles after the transfer edge. RAM model holds 0xDEAD_BEEF.
- Load, addr=0x1000_4000, PRDATA4=0x0000_0041, PREADY4 low for 3 ACCESS cycles:
  - PSEL4 is the only select high.
  - ACCESS lasts 4 cycles, with ready=1 and rdata=0x41 in the 4th.
  - PADDR is stable throughout.
- Unmapped load, addr=0x2000_0000: no PSEL high, ready=1 in ACCESS, rdata=0, FSM back in IDLE.
- rst pulsed while in ACCESS with PREADY3=0: the next cycle is IDLE, PSEL3=0 and PENABLE=0, no ready pulse. A new transfer afterwards completes normally.
- Back-to-back transfers to GPO then GPI, with transfer also pulsed mid-transaction: the mid-transaction pulse is ignored and each transfer gets exactly one ready pulse.
